io_uart_tx_controller: RTL and testbench

//  IO-module peer of the GPIO controller: sits on one IOManager device slot, downstream of the IOOut handshake and upstream of the IOIn writeback.

---
 rtl/io_uart_tx_controller.sv | 209 ++++++++++++++++++++
 tb/tb_io_uart_tx_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx_controller.sv
// IOManager device slot: queues CPU-issued bytes in a small FIFO and serialises
// them as 8N1 UART on UART_TX, with an optional status word written back over IOIn.
module io_uart_tx_controller #(
  parameter int CLKDIV    = 217,
  parameter int FIFODEPTH = 4
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        clk_en,
  output logic        IOOut_ACK,
  input  logic        IOOut_REQ,
  input  logic        IOOut_ResponseRequested,
  input  logic [3:0]  IOOut_DestReg,
  input  logic [15:0] IOOut_Data,
  input  logic        IOIn_ACK,
  output logic        IOIn_REQ,
  output logic        IOIn_RegResponseFlag,
  output logic        IOIn_MemResponseFlag,
  output logic [3:0]  IOIn_DestReg,
  output logic [15:0] IOIn_Data,
  output logic        UART_TX
);

  localparam int PTR_W = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int TMR_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [3:0]       DEPTH_C    = 4'(FIFODEPTH);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKDIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  logic [7:0]       r_mem [FIFODEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;
  tx_state_t        r_state;
  logic [TMR_W-1:0] r_timer;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_uart_tx;
  logic             r_ioin_req;
  logic             r_ioin_reg_flag;
  logic [3:0]       r_ioin_dest;
  logic [15:0]      r_ioin_data;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_consume;
  logic             w_timer_zero;
  logic             w_frame_slot;
  logic             w_busy_next;
  logic [3:0]       w_count_next;
  logic             w_line_bit;
  logic             w_unused_data;

  // Reset is folded in so the slot never advertises readiness while held in reset.
  assign IOOut_ACK     = clk_en & async_rst & ~r_ioin_req & (r_count != DEPTH_C);
  assign w_accept      = clk_en & IOOut_REQ & IOOut_ACK;
  assign w_push        = w_accept & (IOOut_Data[15:14] == 2'b00);
  assign w_consume     = clk_en & r_ioin_req & IOIn_ACK;
  assign w_timer_zero  = (r_timer == TMR_W'(0));
  assign w_frame_slot  = (r_state == S_IDLE) | ((r_state == S_STOP) & w_timer_zero);
  assign w_pop         = clk_en & w_frame_slot & (r_count != 4'd0);
  assign w_busy_next   = w_frame_slot ? (r_count != 4'd0) : 1'b1;
  assign w_unused_data = ^IOOut_Data[13:8];

  assign IOIn_REQ             = r_ioin_req;
  assign IOIn_RegResponseFlag = r_ioin_reg_flag;
  assign IOIn_MemResponseFlag = 1'b0;
  assign IOIn_DestReg         = r_ioin_dest;
  assign IOIn_Data            = r_ioin_data;
  assign UART_TX              = r_uart_tx;

  // Next FIFO occupancy after this edge's push and pop.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 4'd1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 4'd1;
    end else begin
      w_count_next = r_count;
    end
  end

  // Line level implied by the current FSM state; registered one edge later.
  always_comb begin
    w_line_bit = 1'b1;
    case (r_state)
      S_IDLE:  w_line_bit = 1'b1;
      S_START: w_line_bit = 1'b0;
      S_DATA:  w_line_bit = r_shift[0];
      S_STOP:  w_line_bit = 1'b1;
      default: w_line_bit = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because Count gates every read.
  always_ff @(posedge clk) begin
    if (clk_en && w_push) begin
      r_mem[r_wr_ptr] <= IOOut_Data[7:0];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= 4'd0;
    end else if (clk_en) begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Transmit FSM with bit timer, shift register and registered line output.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      r_state   <= S_IDLE;
      r_timer   <= TMR_W'(0);
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_uart_tx <= 1'b1;
    end else if (clk_en) begin
      r_uart_tx <= w_line_bit;
      case (r_state)
        S_IDLE: begin
          if (r_count != 4'd0) begin
            r_shift <= r_mem[r_rd_ptr];
            r_timer <= TMR_RELOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_timer_zero) begin
            r_timer   <= TMR_RELOAD;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_DATA: begin
          if (w_timer_zero) begin
            r_timer <= TMR_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_STOP: begin
          if (w_timer_zero) begin
            // Back-to-back frames: a queued byte goes straight into the next start bit.
            if (r_count != 4'd0) begin
              r_shift <= r_mem[r_rd_ptr];
              r_timer <= TMR_RELOAD;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= TMR_W'(0);
        end
      endcase
    end
  end

  // Writeback handshake: status captured on the accepting edge, held until consumed.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      r_ioin_req      <= 1'b0;
      r_ioin_reg_flag <= 1'b0;
      r_ioin_dest     <= 4'd0;
      r_ioin_data     <= 16'd0;
    end else if (clk_en) begin
      if (w_consume) begin
        r_ioin_req      <= 1'b0;
        r_ioin_reg_flag <= 1'b0;
      end else if (w_accept && IOOut_ResponseRequested) begin
        r_ioin_req      <= 1'b1;
        r_ioin_reg_flag <= 1'b1;
        r_ioin_dest     <= IOOut_DestReg;
        r_ioin_data     <= {11'd0, w_busy_next, w_count_next};
      end
    end
  end

endmodule

// File: tb/tb_io_uart_tx_controller.sv
// Scoreboard bench for io_uart_tx_controller: stimulus queues expected bytes and
// writebacks; independent monitors decode the UART line and the IOIn handshake.
module tb_io_uart_tx_controller;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        async_rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        IOOut_ACK;
  logic        IOOut_REQ = 1'b0;
  logic        IOOut_ResponseRequested = 1'b0;
  logic [3:0]  IOOut_DestReg = 4'd0;
  logic [15:0] IOOut_Data = 16'd0;
  logic        IOIn_ACK = 1'b0;
  logic        IOIn_REQ;
  logic        IOIn_RegResponseFlag;
  logic        IOIn_MemResponseFlag;
  logic [3:0]  IOIn_DestReg;
  logic [15:0] IOIn_Data;
  logic        UART_TX;

  io_uart_tx_controller #(.CLKDIV(DIV), .FIFODEPTH(DEPTH)) dut (
    .clk                     (clk),
    .async_rst               (async_rst),
    .clk_en                  (clk_en),
    .IOOut_ACK               (IOOut_ACK),
    .IOOut_REQ               (IOOut_REQ),
    .IOOut_ResponseRequested (IOOut_ResponseRequested),
    .IOOut_DestReg           (IOOut_DestReg),
    .IOOut_Data              (IOOut_Data),
    .IOIn_ACK                (IOIn_ACK),
    .IOIn_REQ                (IOIn_REQ),
    .IOIn_RegResponseFlag    (IOIn_RegResponseFlag),
    .IOIn_MemResponseFlag    (IOIn_MemResponseFlag),
    .IOIn_DestReg            (IOIn_DestReg),
    .IOIn_Data               (IOIn_Data),
    .UART_TX                 (UART_TX)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_bytes[$];
  logic [19:0] exp_rsp[$];

  // clk_en as seen by the most recent rising edge
  logic en_q = 1'b0;
  always @(posedge clk) en_q <= clk_en;

  int         dec_t = 0;
  bit         dec_busy = 1'b0;
  bit         dec_ok = 1'b1;
  bit         dec_unexp = 1'b0;
  logic [9:0] dec_bits = 10'd0;
  logic [9:0] dec_obs = 10'd0;
  int         dec_gap = 1;
  int         contig = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // UART line monitor: counts enabled edges only, checks every sample of each frame
  initial begin
    forever begin
      @(negedge clk);
      if (!async_rst) begin
        dec_busy = 1'b0;
        dec_gap  = 1;
      end else if (en_q) begin
        if (!dec_busy) begin
          if (UART_TX === 1'b0) begin
            if (dec_gap == 0) contig++;
            dec_busy  = 1'b1;
            dec_t     = 0;
            dec_ok    = 1'b1;
            dec_unexp = 1'b0;
            if (exp_bytes.size() == 0) begin
              dec_unexp = 1'b1;
              dec_bits  = 10'h3FE;
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_frame: got start bit expected idle line");
            end else begin
              dec_bits = {1'b1, exp_bytes.pop_front(), 1'b0};
            end
          end else begin
            dec_gap++;
          end
        end
        if (dec_busy) begin
          if (UART_TX !== dec_bits[dec_t / DIV]) dec_ok = 1'b0;
          if ((dec_t % DIV) == DIV / 2) dec_obs[dec_t / DIV] = UART_TX;
          dec_t++;
          if (dec_t == 10 * DIV) begin
            dec_busy = 1'b0;
            dec_gap  = 0;
            if (!dec_unexp) begin
              n_cmp++;
              if (!dec_ok) begin
                n_err++;
                $display("FAIL uart_frame: got bits 0x%0h expected 0x%0h", dec_obs, dec_bits);
              end
            end
          end
        end
      end
    end
  end

  // Writeback monitor: compares each new IOIn_REQ against the response queue
  initial begin
    logic        req_q;
    logic [19:0] e;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (IOIn_REQ === 1'b1 && req_q !== 1'b1) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: got data 0x%0h expected no writeback", IOIn_Data);
        end else begin
          e = exp_rsp.pop_front();
          if ({IOIn_DestReg, IOIn_Data, IOIn_RegResponseFlag, IOIn_MemResponseFlag} !== {e, 2'b10}) begin
            n_err++;
            $display("FAIL rsp: got dest %0d data 0x%0h flags %b%b expected dest %0d data 0x%0h flags 10",
                     IOIn_DestReg, IOIn_Data, IOIn_RegResponseFlag, IOIn_MemResponseFlag, e[19:16], e[15:0]);
          end
        end
      end
      req_q = IOIn_REQ;
    end
  end

  task automatic cmd(input logic [15:0] d, input logic rr, input logic [3:0] dest,
                     input logic [15:0] exp_st);
    int waited;
    waited = 0;
    IOOut_Data = d;
    IOOut_ResponseRequested = rr;
    IOOut_DestReg = dest;
    IOOut_REQ = 1'b1;
    @(negedge clk);
    while (IOOut_ACK !== 1'b1 && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (IOOut_ACK === 1'b1) begin
      if (d[15:14] == 2'b00) exp_bytes.push_back(d[7:0]);
      if (rr) exp_rsp.push_back({dest, exp_st});
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_timeout: got IOOut_ACK=0 expected 1 for cmd 0x%0h", d);
    end
    @(posedge clk);
    #1;
    IOOut_REQ = 1'b0;
    IOOut_ResponseRequested = 1'b0;
  endtask

  task automatic ack_rsp();
    IOIn_ACK = 1'b1;
    @(posedge clk);
    #1;
    IOIn_ACK = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || dec_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_bytes.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before 600us");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    bit  ok;
    logic v;

    // Reset state, sampled before any clock edge
    #1 async_rst = 1'b0;
    #3;
    chk("rst_uart_tx", {31'd0, UART_TX}, 32'd1);
    chk("rst_ioout_ack", {31'd0, IOOut_ACK}, 32'd0);
    chk("rst_ioin", {11'd0, IOIn_REQ, IOIn_RegResponseFlag, IOIn_MemResponseFlag, IOIn_DestReg, IOIn_Data}, 32'd0);
    repeat (3) @(posedge clk);
    #2 async_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ack", {31'd0, IOOut_ACK}, 32'd1);

    // T1: single byte, start bit from edge N+2
    cmd(16'h00A5, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_latency_n1", {31'd0, UART_TX}, 32'd1);
    @(negedge clk);
    chk("t1_latency_n2", {31'd0, UART_TX}, 32'd0);
    wait_idle();
    cmd(16'h4000, 1'b1, 4'd1, 16'h0000);
    ack_rsp();
    chk("t1_rsp_cleared", {30'd0, IOIn_REQ, IOIn_RegResponseFlag}, 32'd0);

    // T2: six pushes, FIFO fills, frames contiguous
    c0 = contig;
    cmd(16'h0001, 1'b0, 4'd0, 16'd0);
    cmd(16'h0080, 1'b0, 4'd0, 16'd0);
    cmd(16'h007E, 1'b0, 4'd0, 16'd0);
    cmd(16'h00FF, 1'b0, 4'd0, 16'd0);
    cmd(16'h0000, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    chk("t2_ack_full", {31'd0, IOOut_ACK}, 32'd0);
    cmd(16'h005A, 1'b0, 4'd0, 16'd0);
    wait_idle();
    chk("t2_contiguous", contig - c0, 32'd5);

    // T3: status read mid-frame with two queued, writeback held
    cmd(16'h0011, 1'b0, 4'd0, 16'd0);
    cmd(16'h0022, 1'b0, 4'd0, 16'd0);
    cmd(16'h0033, 1'b0, 4'd0, 16'd0);
    cmd(16'h4000, 1'b1, 4'd5, 16'h0012);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (IOIn_REQ !== 1'b1 || IOIn_DestReg !== 4'd5 || IOIn_Data !== 16'h0012 || IOOut_ACK !== 1'b0)
        ok = 1'b0;
    end
    chk("t3_hold_stable", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    ack_rsp();
    chk("t3_rsp_cleared", {30'd0, IOIn_REQ, IOIn_RegResponseFlag}, 32'd0);
    wait_idle();

    // T4: no-effect command and push without response
    cmd(16'hC0FF, 1'b0, 4'd0, 16'd0);
    cmd(16'h003C, 1'b0, 4'd2, 16'd0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (IOIn_REQ !== 1'b0) ok = 1'b0;
    end
    chk("t4_no_rsp", {31'd0, ok}, 32'd1);
    wait_idle();

    // T5: clock enable dropped for 7 cycles during a data bit
    cmd(16'h0096, 1'b0, 4'd0, 16'd0);
    repeat (12) @(posedge clk);
    #1 clk_en = 1'b0;
    v  = UART_TX;
    ok = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (UART_TX !== v || IOOut_ACK !== 1'b0 || IOIn_REQ !== 1'b0) ok = 1'b0;
      @(posedge clk);
    end
    #1 clk_en = 1'b1;
    chk("t5_frozen", {31'd0, ok}, 32'd1);
    wait_idle();

    // T6: async reset during DATA with three queued and a writeback pending
    cmd(16'h0044, 1'b0, 4'd0, 16'd0);
    cmd(16'h0055, 1'b0, 4'd0, 16'd0);
    cmd(16'h0066, 1'b0, 4'd0, 16'd0);
    cmd(16'h0077, 1'b0, 4'd0, 16'd0);
    cmd(16'h4000, 1'b1, 4'd3, 16'h0013);
    repeat (6) @(posedge clk);
    #2 async_rst = 1'b0;
    exp_bytes.delete();
    #1;
    chk("t6_rst_uart_tx", {31'd0, UART_TX}, 32'd1);
    chk("t6_rst_ioin_req", {31'd0, IOIn_REQ}, 32'd0);
    chk("t6_rst_ioin_data", {16'd0, IOIn_Data}, 32'd0);
    repeat (3) @(posedge clk);
    #2 async_rst = 1'b1;
    @(posedge clk);
    #1;
    cmd(16'h4000, 1'b1, 4'd7, 16'h0000);
    ack_rsp();
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (UART_TX !== 1'b1) ok = 1'b0;
    end
    chk("t6_line_idle", {31'd0, ok}, 32'd1);

    wait_idle();
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
